mem_responder: RTL
==================

Name: mem_responder

Overview:
- Byte-wide memory-side responder for the CPU memory controller's RAM bus.
- Serves controller reads and writes against an internal byte RAM.
- Decodes the I/O window: output-byte transmit FIFO, input-byte receive port, program-halt register.
- Drives io_buffer_full back to the controller so it stalls before the transmit FIFO overflows.

Parameters:
- RAM_AW, 17: RAM address width; depth 2^RAM_AW bytes.
- TX_DEPTH, 8: transmit FIFO depth in bytes; power of two, at least 4.
- FULL_MARGIN, 2: io_buffer_full asserts when the free-entry count is at or below this value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global ready; when low the block holds all state
- mem_rw  in  1  1 = write, 0 = read
- mem_addr  in  32  byte address from the controller
- mem_din  in  8  write data from the controller
- mem_dout  out  8  read data to the controller
- io_buffer_full  out  1  transmit FIFO near-full; stall request to the controller
- tx_valid  out  1  transmit FIFO non-empty
- tx_data  out  8  transmit FIFO head byte
- tx_ready  in  1  downstream consumes the head byte when high with tx_valid
- rx_valid  in  1  input byte available
- rx_data  in  8  input byte
- rx_pop  out  1  one-cycle pulse: input byte consumed
- halt  out  1  sticky program-end flag
- tx_overflow  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset values:
  - mem_dout = 0; FIFO empty (pointers and count 0).
  - io_buffer_full = 0, tx_valid = 0, rx_pop = 0, halt = 0, tx_overflow = 0.
  - RAM contents are not cleared.
- Decode:
  - I/O space when mem_addr[17:16] == 2'b11; otherwise RAM at mem_addr[RAM_AW-1:0].
  - I/O offset 0x0 is DATA; offset 0x4 is HALT; other I/O offsets read 0 and writes are ignored.
- All actions below occur on a rising clk edge with rdy = 1.
- RAM write (rw = 1): RAM[addr] <= mem_din. mem_dout is unchanged.
- RAM read (rw = 0): mem_dout <= RAM[addr]. Latency is 1 cycle: an address presented in cycle n returns its data in cycle n+1. This matches the controller's stage-offset capture.
- I/O write to DATA:
  - Push mem_din into the transmit FIFO.
  - If the FIFO is full, drop the byte and set tx_overflow.
- I/O write to HALT: set halt. It stays set until reset.
- I/O read from DATA:
  - If rx_valid: mem_dout <= rx_data, and rx_pop pulses high for that one cycle.
  - If not rx_valid: mem_dout <= 0 and no pop.
- I/O read from HALT: mem_dout <= {7'b0, halt}.
- Controller idle convention: an idle controller presents rw = 0. Idle-cycle reads update mem_dout and have no side effects, except at the I/O DATA address.
- Transmit FIFO:
  - Circular buffer with separate read and write pointers plus a count.
  - Pointers wrap modulo TX_DEPTH.
  - Pop occurs when tx_valid && tx_ready.
  - tx_data is the combinational head entry.
- Simultaneous push and pop:
  - In the same cycle, count is unchanged and both pointers advance.
  - When the FIFO is full, a simultaneous pop makes room, so the push is accepted and overflow is not flagged.
- io_buffer_full is registered: high when (TX_DEPTH - count_next) <= FULL_MARGIN. It updates the cycle after the push or pop that changes count.
- rdy = 0:
  - No RAM write, no FIFO push, no pop on either port.
  - rx_pop = 0; mem_dout holds; flags hold.
  - tx_valid and tx_data still reflect FIFO state.
- Reset mid-operation: a multi-byte store in flight is abandoned. Bytes already written stay in RAM; FIFO contents are discarded.
- Reads of undefined RAM addresses return whatever the RAM holds. The bench preloads the RAM.

Test Plan:
- RAM byte write then read: write 0xA5 to 0x0010; next cycle rw = 0, addr = 0x0010 -> mem_dout = 0xA5 one cycle later.
- Four-byte store then word read: bytes 0x78, 0x56, 0x34, 0x12 written to 0x100..0x103; sequential reads -> mem_dout yields 0x78, 0x56, 0x34, 0x12 on consecutive cycles, each 1 cycle after its address.
- Transmit FIFO fill with tx_ready = 0, TX_DEPTH = 8:
  - After the 6th push (free entries = 2), io_buffer_full = 1 on the next cycle.
  - The 9th push is dropped and sets tx_overflow = 1.
  - After tx_ready = 1, tx_data drains in push order.
- Simultaneous push and pop on a full FIFO: push accepted, count stays 8, tx_overflow stays 0.
- Input read: rx_valid = 1, rx_data = 0x41, read 0x30000 -> mem_dout = 0x41 and rx_pop pulses once. Repeat with rx_valid = 0 -> mem_dout = 0x00 and no pulse.
- Halt and reset: write 0x30004 -> halt = 1 and reads of 0x30004 return 0x01. Assert rst mid-FIFO-drain -> tx_valid = 0, halt = 0, io_buffer_full = 0 on the next cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide RAM-bus responder: internal byte RAM plus an I/O window (transmit FIFO, receive port, halt flag).
// Reads return one cycle after the address; io_buffer_full warns the controller before the transmit FIFO fills.
module mem_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        mem_rw,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

    logic [7:0]    ram [2**RAM_AW];
    logic [7:0]    tx_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;

    logic       is_io, sel_data, sel_halt;
    logic       push_req, push_ok, pop, ram_we, rd_en;
    logic [7:0] ram_rd, io_rd, io_rd_next;
    logic       rd_src_ram;
    logic       unused_addr;

    assign is_io    = (mem_addr[17:16] == 2'b11);
    assign sel_data = is_io && (mem_addr[15:0] == 16'h0000);
    assign sel_halt = is_io && (mem_addr[15:0] == 16'h0004);
    assign unused_addr = ^mem_addr[31:18];

    assign tx_valid = (count != '0);
    assign tx_data  = tx_mem[rd_ptr];
    assign pop      = rdy && tx_valid && tx_ready;
    assign push_req = rdy && mem_rw && sel_data;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && ((count != DEPTH_C) || pop);
    assign ram_we   = !rst && rdy && mem_rw && !is_io;
    assign rd_en    = rdy && !mem_rw;
    assign rx_pop   = !rst && rd_en && sel_data && rx_valid;

    assign mem_dout = rd_src_ram ? ram_rd : io_rd;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        io_rd_next = 8'h00;
        if (sel_data && rx_valid) io_rd_next = rx_data;
        else if (sel_halt)        io_rd_next = {7'b0, halt};
    end

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we)  ram[mem_addr[RAM_AW-1:0]] <= mem_din;
        if (rd_en)   ram_rd <= ram[mem_addr[RAM_AW-1:0]];
        if (push_ok) tx_mem[wr_ptr] <= mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_src_ram     <= 1'b0;
            io_rd          <= 8'h00;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            halt           <= 1'b0;
            tx_overflow    <= 1'b0;
        end else if (rdy) begin
            if (!mem_rw) begin
                rd_src_ram <= !is_io;
                io_rd      <= io_rd_next;
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count          <= count_next;
            io_buffer_full <= ((DEPTH_C - count_next) <= MARGIN_C);
            if (push_req && !push_ok) tx_overflow <= 1'b1;
            if (mem_rw && sel_halt)   halt <= 1'b1;
        end
    end
endmodule
